// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode constants and shifter mode encoding for alu_unit
package alu_pkg;

  localparam int ALU_WIDTH   = 16;
  localparam int ALU_SHIFT_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_mode_e;

  // Non-shift opcodes map to SRL; the shifter output is simply not selected for them.
  function automatic shift_mode_e op_to_shift_mode(input logic [2:0] op);
    shift_mode_e mode;
    case (op)
      OP_SLL:  mode = SH_SLL;
      OP_SRA:  mode = SH_SRA;
      default: mode = SH_SRL;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational log2-stage barrel shifter (SLL/SRL/SRA)
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHIFT_W = ALU_SHIFT_W
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHIFT_W-1:0] amount,
  input  shift_mode_e        mode,
  output logic [WIDTH-1:0]   result
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int k = 0; k < WIDTH; k++) begin
      r[k] = v[WIDTH-1-k];
    end
    return r;
  endfunction

  logic             left;
  logic             fill;
  logic [WIDTH-1:0] cur;

  // Left shifts reuse the right-shift stages on the bit-reversed operand.
  always_comb begin
    left = (mode == SH_SLL);
    fill = (mode == SH_SRA) && data[WIDTH-1];
    cur  = left ? bit_reverse(data) : data;
    for (int i = 0; i < SHIFT_W; i++) begin
      if (amount[i]) begin
        cur = (cur >> (1 << i)) | (fill ? ~(ONES >> (1 << i)) : '0);
      end
    end
    result = left ? bit_reverse(cur) : cur;
  end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - 16-bit registered execute-stage ALU with signed-overflow flag
// ALU_FLAGS_EN adds registered ALU_Zero / ALU_Neg outputs.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHIFT_W = ALU_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   ALU_DA,
  input  logic [WIDTH-1:0]   ALU_DB,
  input  logic [2:0]         ALU_CTL,
  input  logic [SHIFT_W-1:0] ALU_SHIFT,
  output logic [WIDTH-1:0]   ALU_DC,
  output logic               ALU_OverFlow
`ifdef ALU_FLAGS_EN
  ,
  output logic               ALU_Zero,
  output logic               ALU_Neg
`endif
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shift_res;
  shift_mode_e      shift_mode;

  logic [WIDTH-1:0] dc_d, dc_q;
  logic             ovf_d, ovf_q;

  assign shift_mode = op_to_shift_mode(ALU_CTL);

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_shifter (
    .data   (ALU_DA),
    .amount (ALU_SHIFT),
    .mode   (shift_mode),
    .result (shift_res)
  );

  always_comb begin
    sum   = ALU_DA + ALU_DB;
    diff  = ALU_DA - ALU_DB;
    dc_d  = '0;
    ovf_d = 1'b0;
    case (ALU_CTL)
      OP_ADD: begin
        dc_d  = sum;
        ovf_d = (ALU_DA[WIDTH-1] == ALU_DB[WIDTH-1]) && (sum[WIDTH-1] != ALU_DA[WIDTH-1]);
      end
      OP_SUB: begin
        dc_d  = diff;
        ovf_d = (ALU_DA[WIDTH-1] != ALU_DB[WIDTH-1]) && (diff[WIDTH-1] != ALU_DA[WIDTH-1]);
      end
      OP_AND:                 dc_d = ALU_DA & ALU_DB;
      OP_OR:                  dc_d = ALU_DA | ALU_DB;
      OP_XOR:                 dc_d = ALU_DA ^ ALU_DB;
      OP_SLL, OP_SRL, OP_SRA: dc_d = shift_res;
      default:                dc_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      dc_q  <= dc_d;
      ovf_q <= ovf_d;
    end
  end

  assign ALU_DC       = dc_q;
  assign ALU_OverFlow = ovf_q;

`ifdef ALU_FLAGS_EN
  logic zero_d, zero_q;
  logic neg_d, neg_q;

  always_comb begin
    zero_d = (dc_d == '0);
    neg_d  = dc_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign ALU_Zero = zero_q;
  assign ALU_Neg  = neg_q;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit against an arithmetic reference model
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ALU_DA = '0;
  logic [15:0] ALU_DB = '0;
  logic [2:0]  ALU_CTL = '0;
  logic [3:0]  ALU_SHIFT = '0;
  logic [15:0] ALU_DC;
  logic        ALU_OverFlow;
`ifdef ALU_FLAGS_EN
  logic        ALU_Zero;
  logic        ALU_Neg;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [15:0] exp_dc  = '0;
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  alu_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ALU_DA       (ALU_DA),
    .ALU_DB       (ALU_DB),
    .ALU_CTL      (ALU_CTL),
    .ALU_SHIFT    (ALU_SHIFT),
    .ALU_DC       (ALU_DC),
    .ALU_OverFlow (ALU_OverFlow)
`ifdef ALU_FLAGS_EN
    ,
    .ALU_Zero     (ALU_Zero),
    .ALU_Neg      (ALU_Neg)
`endif
  );

  // Reference: signed integer arithmetic for overflow, SV operators for logic/shift.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op, input logic [3:0] sh);
    int          sa;
    int          sb;
    int          r;
    logic [15:0] y;
    logic        v;
    sa = $signed(a);
    sb = $signed(b);
    v  = 1'b0;
    y  = '0;
    case (op)
      3'd0: begin r = sa + sb; v = (r > 32767) || (r < -32768); y = r[15:0]; end
      3'd1: begin r = sa - sb; v = (r > 32767) || (r < -32768); y = r[15:0]; end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << sh;
      3'd6: y = a >> sh;
      default: y = $signed(a) >>> sh;
    endcase
    return {v, y};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present inputs mid-cycle, confirm output still holds the previous result, then check after the edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input logic [3:0] sh, input string tag);
    logic [16:0] e;
    @(negedge clk);
    ALU_DA = a; ALU_DB = b; ALU_CTL = op; ALU_SHIFT = sh;
    #1;
    check({tag, "_hold"}, ALU_DC, exp_dc);
    e = model(a, b, op, sh);
    @(posedge clk);
    #1;
    check(tag, ALU_DC, e[15:0]);
    check({tag, "_ovf"}, {15'd0, ALU_OverFlow}, {15'd0, e[16]});
`ifdef ALU_FLAGS_EN
    check({tag, "_zero"}, {15'd0, ALU_Zero}, {15'd0, (e[15:0] == 16'd0)});
    check({tag, "_neg"}, {15'd0, ALU_Neg}, {15'd0, e[15]});
`endif
    exp_dc  = e[15:0];
    exp_ovf = e[16];
  endtask

  task automatic dstep(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [3:0] sh, input logic [15:0] want_dc, input logic want_ovf,
                       input string tag);
    step(a, b, op, sh, tag);
    check({tag, "_const"}, ALU_DC, want_dc);
    check({tag, "_const_ovf"}, {15'd0, ALU_OverFlow}, {15'd0, want_ovf});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_dc", ALU_DC, 16'h0000);
    check("reset_ovf", {15'd0, ALU_OverFlow}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    step(16'h1234, 16'h5678, 3'b000, 4'd0, "pre_reset_add");
    check("pre_reset_const", ALU_DC, 16'h68AC);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_dc", ALU_DC, 16'h0000);
    check("async_reset_ovf", {15'd0, ALU_OverFlow}, 16'h0000);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_held_dc", ALU_DC, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_dc  = '0;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_after_reset", ALU_DC, 16'h68AC);
    exp_dc = 16'h68AC;

    dstep(16'hFFF0, 16'h0FF0, 3'b010, 4'd3, 16'h0FF0, 1'b0, "and");
    dstep(16'hFFF0, 16'h0FF0, 3'b011, 4'd3, 16'hFFF0, 1'b0, "or");
    dstep(16'hFFF0, 16'h0FF0, 3'b100, 4'd3, 16'hF000, 1'b0, "xor");

    dstep(16'h7FFF, 16'h0001, 3'b000, 4'd0, 16'h8000, 1'b1, "add_ovf");
    dstep(16'hFFFF, 16'h0001, 3'b000, 4'd0, 16'h0000, 1'b0, "add_wrap");
    dstep(16'h8000, 16'h0001, 3'b001, 4'd0, 16'h7FFF, 1'b1, "sub_ovf");

    dstep(16'h0001, 16'hFFFF, 3'b101, 4'd15, 16'h8000, 1'b0, "sll15");
    dstep(16'h8000, 16'hFFFF, 3'b110, 4'd4, 16'h0800, 1'b0, "srl4");
    dstep(16'h8000, 16'h0000, 3'b111, 4'd4, 16'hF800, 1'b0, "sra4");
    dstep(16'hA5C3, 16'h1111, 3'b111, 4'd0, 16'hA5C3, 1'b0, "sra0");
    dstep(16'hFFFF, 16'h0000, 3'b110, 4'd15, 16'h0001, 1'b0, "srl15");
    dstep(16'h8001, 16'h0000, 3'b111, 4'd15, 16'hFFFF, 1'b0, "sra15");
    dstep(16'h7FFE, 16'h0000, 3'b101, 4'd15, 16'h0000, 1'b0, "sll15_zero");

    dstep(16'h0001, 16'h0002, 3'b000, 4'd0, 16'h0003, 1'b0, "b2b_add");
    dstep(16'h0005, 16'h0007, 3'b001, 4'd0, 16'hFFFE, 1'b0, "b2b_sub");
    dstep(16'h00F3, 16'h0F0F, 3'b010, 4'd0, 16'h0003, 1'b0, "b2b_and");

    dstep(16'h0005, 16'h0005, 3'b001, 4'd0, 16'h0000, 1'b0, "sub_zero");
    dstep(16'h0005, 16'h0007, 3'b001, 4'd0, 16'hFFFE, 1'b0, "sub_neg");

    for (int n = 0; n < 300; n++) begin
      step(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
